// File: rtl/nec_command_decoder_if.sv
// Receiver-side frame inputs and consumer-side command FIFO handshake for nec_command_decoder.
interface nec_command_decoder_if;
  logic        rxReadyIN;
  logic [31:0] rxDataIN;
  logic        cmdValidOUT;
  logic        cmdReadyIN;
  logic [15:0] cmdAddressOUT;
  logic [7:0]  cmdCommandOUT;
  logic        cmdRepeatOUT;
  logic [7:0]  errorCountOUT;
  logic        overflowOUT;

  modport master (
    output rxReadyIN, rxDataIN, cmdReadyIN,
    input  cmdValidOUT, cmdAddressOUT, cmdCommandOUT, cmdRepeatOUT, errorCountOUT, overflowOUT
  );

  modport slave (
    input  rxReadyIN, rxDataIN, cmdReadyIN,
    output cmdValidOUT, cmdAddressOUT, cmdCommandOUT, cmdRepeatOUT, errorCountOUT, overflowOUT
  );
endinterface

// File: rtl/nec_command_decoder.sv
// Validates raw NEC frames from the IR receiver, tags auto-repeats by timing,
// and queues accepted commands in a 4-entry FIFO for the effect controller.
module nec_command_decoder #(
  parameter bit          STRICT_ADDRESS    = 1'b1,
  parameter bit          ADDRESS_FILTER_EN = 1'b0,
  parameter logic [15:0] ADDRESS_VALUE     = 16'hFF00,
  parameter int unsigned REPEAT_WINDOW     = 6_000_000
) (
  input logic                  clkIN,
  input logic                  nResetIN,
  nec_command_decoder_if.slave bus
);

  localparam logic [23:0] WINDOW = 24'(REPEAT_WINDOW);

  typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;

  state_t      state_q, state_d;
  logic        rx_prev_q;
  logic [31:0] frame_q, frame_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        ovf_q, ovf_d;
  logic [23:0] timer_q, timer_d;
  logic [23:0] last_q, last_d;
  logic [24:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic [7:0]  addr, addr_inv, cmd, cmd_inv;
  logic [15:0] addr16;
  logic [23:0] key;
  logic        rise, comp_err, filtered;
  logic        capture, check_err, push, pop, full, wr_en, is_repeat;

  // NEC sends LSB first but the receiver shifts MSB first.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign addr     = rev8(frame_q[31:24]);
  assign addr_inv = rev8(frame_q[23:16]);
  assign cmd      = rev8(frame_q[15:8]);
  assign cmd_inv  = rev8(frame_q[7:0]);
  assign addr16   = {addr_inv, addr};
  assign key      = {addr16, cmd};

  assign rise     = bus.rxReadyIN && !rx_prev_q;
  assign comp_err = (cmd != ~cmd_inv) || (STRICT_ADDRESS && (addr != ~addr_inv));
  assign filtered = ADDRESS_FILTER_EN && (addr16 != ADDRESS_VALUE);

  always_ff @(posedge clkIN) begin
    if (!nResetIN) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = CHECK;
      CHECK:   state_d = (comp_err || filtered) ? IDLE : PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state_q == IDLE) && rise;
    check_err = (state_q == CHECK) && comp_err;
    push      = (state_q == PUSH);
  end

  assign is_repeat = (timer_q != '0) && (key == last_q);
  assign pop       = (count_q != '0) && bus.cmdReadyIN;
  assign full      = (count_q == 3'd4);
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign wr_en     = push && (!full || pop);

  always_comb begin
    frame_d   = capture ? bus.rxDataIN : frame_q;
    err_cnt_d = (check_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    ovf_d     = ovf_q || (push && full && !pop);
    timer_d   = push ? WINDOW : ((timer_q != '0) ? timer_q - 24'd1 : timer_q);
    last_d    = push ? key : last_q;
    wr_ptr_d  = wr_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d   = count_q + {2'b00, wr_en} - {2'b00, pop};
  end

  always_ff @(posedge clkIN) begin
    if (!nResetIN) begin
      rx_prev_q <= 1'b1;
      frame_q   <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      last_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      rx_prev_q <= bus.rxReadyIN;
      frame_q   <= frame_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= {is_repeat, key};
    end
  end

  assign bus.cmdValidOUT   = (count_q != '0);
  assign bus.cmdRepeatOUT  = mem_q[rd_ptr_q][24];
  assign bus.cmdAddressOUT = mem_q[rd_ptr_q][23:8];
  assign bus.cmdCommandOUT = mem_q[rd_ptr_q][7:0];
  assign bus.errorCountOUT = err_cnt_q;
  assign bus.overflowOUT   = ovf_q;

endmodule

// File: tb/tb_nec_command_decoder.sv
// Self-checking bench for nec_command_decoder against a queue-based reference model.
module tb_nec_command_decoder;

  localparam int unsigned WIN = 2000;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        cmd_ready;
  longint      cycle = 0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  nec_command_decoder_if bus();
  nec_command_decoder_if busf();

  assign bus.rxReadyIN  = rx_ready;
  assign bus.rxDataIN   = rx_data;
  assign bus.cmdReadyIN = cmd_ready;
  assign busf.rxReadyIN  = rx_ready;
  assign busf.rxDataIN   = rx_data;
  assign busf.cmdReadyIN = cmd_ready;

  nec_command_decoder #(
    .STRICT_ADDRESS(1'b1), .ADDRESS_FILTER_EN(1'b0),
    .ADDRESS_VALUE(16'hFF00), .REPEAT_WINDOW(WIN)
  ) dut (.clkIN(clk), .nResetIN(n_reset), .bus(bus));

  nec_command_decoder #(
    .STRICT_ADDRESS(1'b1), .ADDRESS_FILTER_EN(1'b1),
    .ADDRESS_VALUE(16'hFF00), .REPEAT_WINDOW(WIN)
  ) dutf (.clkIN(clk), .nResetIN(n_reset), .bus(busf));

  // Reference model: expected FIFO contents as {repeat, address16, command}.
  logic [24:0] mq[$];
  int unsigned m_err;
  bit          m_ovf;
  bit          m_have_last;
  logic [23:0] m_last_key;
  longint      m_last_t;

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], b[i]};
    return r;
  endfunction

  function automatic logic [31:0] make_frame(input logic [7:0] a, input logic [7:0] c);
    return {bitrev(a), bitrev(~a), bitrev(c), bitrev(~c)};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_err = 0;
    m_ovf = 0;
    m_have_last = 0;
    m_last_key = '0;
    m_last_t = 0;
  endfunction

  function automatic void model_frame(input logic [31:0] raw, input longint t);
    logic [7:0] a, ai, c, ci;
    logic [23:0] k;
    logic rep;
    a  = bitrev(raw[31:24]);
    ai = bitrev(raw[23:16]);
    c  = bitrev(raw[15:8]);
    ci = bitrev(raw[7:0]);
    if (c != ~ci || a != ~ai) begin
      if (m_err < 255) m_err++;
      return;
    end
    k = {ai, a, c};
    rep = m_have_last && (k == m_last_key) && ((t - m_last_t) <= longint'(WIN));
    if (mq.size() < 4) mq.push_back({rep, k});
    else m_ovf = 1;
    m_have_last = 1;
    m_last_key = k;
    m_last_t = t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    n_reset = 0; rx_ready = 0; cmd_ready = 0;
    @(negedge clk);
    n_reset = 1;
    model_reset();
  endtask

  task automatic send_frame(input logic [31:0] raw);
    longint t;
    @(negedge clk);
    rx_data = raw; rx_ready = 1; t = cycle;
    @(negedge clk);
    rx_ready = 0;
    @(negedge clk);
    @(negedge clk);
    model_frame(raw, t);
  endtask

  task automatic pop_head(output logic v, output logic [24:0] h);
    @(negedge clk);
    v = bus.cmdValidOUT;
    h = {bus.cmdRepeatOUT, bus.cmdAddressOUT, bus.cmdCommandOUT};
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
  endtask

  task automatic test_reset();
    n_reset = 0; rx_ready = 0; cmd_ready = 0; rx_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.cmdValidOUT); end
    checks++; if (bus.cmdAddressOUT !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bus.cmdAddressOUT); end
    checks++; if (bus.cmdCommandOUT !== 8'h0) begin errors++; $display("FAIL reset_cmd: got %h expected 00", bus.cmdCommandOUT); end
    checks++; if (bus.cmdRepeatOUT !== 1'b0) begin errors++; $display("FAIL reset_rep: got %b expected 0", bus.cmdRepeatOUT); end
    checks++; if (bus.errorCountOUT !== 8'h0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.errorCountOUT); end
    checks++; if (bus.overflowOUT !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflowOUT); end
    n_reset = 1;
    model_reset();
  endtask

  task automatic test_valid_frame();
    logic v;
    logic [24:0] h;
    longint t;
    do_reset();
    @(negedge clk);
    rx_data = 32'h00FFA25D; rx_ready = 1; t = cycle;
    @(negedge clk);
    rx_ready = 0;
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL lat_k: got %b expected 0", bus.cmdValidOUT); end
    @(negedge clk);
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL lat_k1: got %b expected 0", bus.cmdValidOUT); end
    @(negedge clk);
    model_frame(32'h00FFA25D, t);
    checks++; if (bus.cmdValidOUT !== 1'b1) begin errors++; $display("FAIL lat_k2: got %b expected 1", bus.cmdValidOUT); end
    checks++; if ({bus.cmdRepeatOUT, bus.cmdAddressOUT, bus.cmdCommandOUT} !== {1'b0, 16'hFF00, 8'h45})
      begin errors++; $display("FAIL valid_head: got %h expected %h", {bus.cmdRepeatOUT, bus.cmdAddressOUT, bus.cmdCommandOUT}, {1'b0, 16'hFF00, 8'h45}); end
    checks++; if (bus.errorCountOUT !== 8'h0) begin errors++; $display("FAIL valid_err: got %0d expected 0", bus.errorCountOUT); end
    pop_head(v, h);
    void'(mq.pop_front());
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL valid_popped: got %b expected 0", bus.cmdValidOUT); end
  endtask

  task automatic test_bad_complement();
    do_reset();
    send_frame(32'h00FFA25C);
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b expected 0", bus.cmdValidOUT); end
    checks++; if (bus.errorCountOUT !== 8'd1) begin errors++; $display("FAIL bad_err1: got %0d expected 1", bus.errorCountOUT); end
    for (int i = 0; i < 256; i++) send_frame(32'h00FFA25C);
    checks++; if (bus.errorCountOUT !== 8'd255 || m_err != 255) begin errors++; $display("FAIL bad_sat: got %0d expected 255 (model %0d)", bus.errorCountOUT, m_err); end
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL bad_valid2: got %b expected 0", bus.cmdValidOUT); end
  endtask

  task automatic test_repeat();
    logic v;
    logic [24:0] h;
    logic [2:0] exp_rep;
    exp_rep = 3'b010;
    do_reset();
    send_frame(32'h00FFA25D);
    repeat (996) @(negedge clk);
    send_frame(32'h00FFA25D);
    repeat (2496) @(negedge clk);
    send_frame(32'h00FFA25D);
    for (int i = 0; i < 3; i++) begin
      pop_head(v, h);
      checks++; if (v !== 1'b1 || h !== mq[0] || h[24] !== exp_rep[i])
        begin errors++; $display("FAIL repeat_tag%0d: got v=%b %h expected %h rep=%b", i, v, h, mq[0], exp_rep[i]); end
      void'(mq.pop_front());
    end
    repeat (2500) @(negedge clk);
    send_frame(make_frame(8'h00, 8'h45));
    repeat (500) @(negedge clk);
    send_frame(make_frame(8'h00, 8'h46));
    for (int i = 0; i < 2; i++) begin
      pop_head(v, h);
      checks++; if (v !== 1'b1 || h !== {1'b0, 16'hFF00, 8'h45 + 8'(i)} || h !== mq[0])
        begin errors++; $display("FAIL repeat_diff%0d: got v=%b %h expected %h", i, v, h, {1'b0, 16'hFF00, 8'h45 + 8'(i)}); end
      void'(mq.pop_front());
    end
  endtask

  task automatic test_filter();
    do_reset();
    send_frame(32'h807FA25D);
    checks++; if (busf.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL filter_drop: got %b expected 0", busf.cmdValidOUT); end
    checks++; if (busf.errorCountOUT !== 8'h0) begin errors++; $display("FAIL filter_err: got %0d expected 0", busf.errorCountOUT); end
    checks++; if (bus.cmdValidOUT !== 1'b1 || bus.cmdAddressOUT !== 16'hFE01)
      begin errors++; $display("FAIL nofilter_accept: got v=%b addr=%h expected 1 fe01", bus.cmdValidOUT, bus.cmdAddressOUT); end
    send_frame(32'h00FFA25D);
    checks++; if ({busf.cmdValidOUT, busf.cmdAddressOUT, busf.cmdCommandOUT} !== {1'b1, 16'hFF00, 8'h45})
      begin errors++; $display("FAIL filter_accept: got %h expected %h", {busf.cmdValidOUT, busf.cmdAddressOUT, busf.cmdCommandOUT}, {1'b1, 16'hFF00, 8'h45}); end
    do_reset();
  endtask

  task automatic test_fifo_full();
    logic v;
    logic [24:0] h;
    longint t;
    logic [31:0] raw;
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(make_frame(8'h00, 8'h10 + 8'(i)));
    checks++; if (bus.overflowOUT !== 1'b1 || !m_ovf) begin errors++; $display("FAIL full_ovf: got %b expected 1", bus.overflowOUT); end
    for (int i = 0; i < 4; i++) begin
      pop_head(v, h);
      checks++; if (v !== 1'b1 || h !== mq[0] || h[7:0] !== 8'h10 + 8'(i))
        begin errors++; $display("FAIL full_pop%0d: got v=%b %h expected %h", i, v, h, mq[0]); end
      void'(mq.pop_front());
    end
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", bus.cmdValidOUT); end

    do_reset();
    for (int i = 0; i < 4; i++) send_frame(make_frame(8'h00, 8'h20 + 8'(i)));
    raw = make_frame(8'h00, 8'h30);
    @(negedge clk);
    rx_data = raw; rx_ready = 1; t = cycle;
    @(negedge clk);
    rx_ready = 0;
    @(negedge clk);
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    void'(mq.pop_front());
    model_frame(raw, t);
    checks++; if (bus.overflowOUT !== 1'b0 || m_ovf) begin errors++; $display("FAIL pushpop_ovf: got %b expected 0", bus.overflowOUT); end
    for (int i = 0; i < 4; i++) begin
      pop_head(v, h);
      checks++; if (v !== 1'b1 || h !== mq[0]) begin errors++; $display("FAIL pushpop_pop%0d: got v=%b %h expected %h", i, v, h, mq[0]); end
      void'(mq.pop_front());
    end
    checks++; if (h[7:0] !== 8'h30 || bus.cmdValidOUT !== 1'b0)
      begin errors++; $display("FAIL pushpop_tail: got cmd=%h v=%b expected 30 0", h[7:0], bus.cmdValidOUT); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    send_frame(32'h00FFA25C);
    send_frame(make_frame(8'h00, 8'h01));
    send_frame(make_frame(8'h00, 8'h02));
    @(negedge clk);
    n_reset = 0; rx_data = 32'h00FFA25D; rx_ready = 1;
    @(negedge clk);
    checks++; if ({bus.cmdValidOUT, bus.cmdAddressOUT, bus.cmdCommandOUT, bus.cmdRepeatOUT, bus.errorCountOUT, bus.overflowOUT} !== '0)
      begin errors++; $display("FAIL midop_reset: got v=%b a=%h c=%h r=%b e=%0d o=%b expected all 0", bus.cmdValidOUT, bus.cmdAddressOUT,
        bus.cmdCommandOUT, bus.cmdRepeatOUT, bus.errorCountOUT, bus.overflowOUT); end
    n_reset = 1;
    model_reset();
    repeat (10) @(negedge clk);
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL midop_nocapture: got %b expected 0", bus.cmdValidOUT); end
    rx_ready = 0;
    send_frame(32'h00FFA25D);
    checks++; if (bus.cmdValidOUT !== 1'b1 || bus.cmdCommandOUT !== 8'h45)
      begin errors++; $display("FAIL midop_recapture: got v=%b c=%h expected 1 45", bus.cmdValidOUT, bus.cmdCommandOUT); end
  endtask

  task automatic test_random();
    logic v;
    logic [24:0] h;
    logic [7:0] a, c;
    logic [31:0] raw;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: a = 8'h00;
        1: a = 8'h80;
        default: a = 8'h1F;
      endcase
      c = 8'h45 + 8'($urandom_range(0, 2));
      raw = make_frame(a, c);
      if ($urandom_range(0, 4) == 0) raw = raw ^ (32'h1 << $urandom_range(0, 31));
      send_frame(raw);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(2050, 2200)) @(negedge clk);
      else repeat ($urandom_range(1, 150)) @(negedge clk);
      if ($urandom_range(0, 1) == 1 && mq.size() > 0) begin
        pop_head(v, h);
        checks++; if (v !== 1'b1 || h !== mq[0]) begin errors++; $display("FAIL rand_pop%0d: got v=%b %h expected %h", n, v, h, mq[0]); end
        void'(mq.pop_front());
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (mq.size() > 0) begin
        pop_head(v, h);
        checks++; if (v !== 1'b1 || h !== mq[0]) begin errors++; $display("FAIL rand_drain%0d: got v=%b %h expected %h", i, v, h, mq[0]); end
        void'(mq.pop_front());
      end
    end
    @(negedge clk);
    checks++; if (bus.cmdValidOUT !== 1'b0) begin errors++; $display("FAIL rand_empty: got %b expected 0", bus.cmdValidOUT); end
    checks++; if (bus.errorCountOUT !== 8'(m_err)) begin errors++; $display("FAIL rand_err: got %0d expected %0d", bus.errorCountOUT, m_err); end
    checks++; if (bus.overflowOUT !== m_ovf) begin errors++; $display("FAIL rand_ovf: got %b expected %b", bus.overflowOUT, m_ovf); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_complement();
    test_repeat();
    test_filter();
    test_fifo_full();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
